ptcalc_mul_pipe: RTL and testbench

Parametrised, pipelined signed multiplier for the pT-calculation datapath, replacing the fixed-width, single-stage DSP multipliers. Accepts operand pairs on a valid/ready stream, forms the full-precision product, optionally rounds it right by a fixed shift, narrows it to the output width with overflow detection, and returns it with a user tag after a fixed latency. Throughput is one product per cycle with full backpressure.

---
 rtl/ptcalc_mul_pkg.sv | 32 +++
 rtl/ptcalc_mul_round_sat.sv | 42 ++++
 rtl/ptcalc_mul_pipe.sv | 121 ++++++++++++
 tb/tb_ptcalc_mul_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ptcalc_mul_pkg.sv
// ptcalc_mul_pkg: shared constants and helpers for the pT multiplier.
// Product width, rounding constant and parameter range check.
package ptcalc_mul_pkg;

    localparam int OVF_CNT_W = 16;

    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1;
    endfunction

    // Half-LSB of the shifted result; zero when nothing is shifted out.
    function automatic logic [63:0] round_const(input int shift);
        logic [63:0] one;
        one = 64'd1;
        return (shift > 0) ? (one << (shift - 1)) : 64'd0;
    endfunction

    function automatic bit params_ok(
        input int w0,
        input int w1,
        input int wo,
        input int sh,
        input int ns
    );
        return (w0 >= 2) && (w0 <= 27) &&
               (w1 >= 2) && (w1 <= 27) &&
               (wo >= 2) && (wo <= w0 + w1) &&
               (sh >= 0) && (sh < w0 + w1) &&
               (ns >= 1);
    endfunction

endpackage

// File: rtl/ptcalc_mul_round_sat.sv
// ptcalc_mul_round_sat: round-half-up shift and narrowing of a product.
// Ports: prod (PW-bit signed) in; dout (DOUT_WIDTH), ovf out.
// PTCALC_MUL_SAT_EN selects clamping instead of wrap on overflow.
module ptcalc_mul_round_sat
    import ptcalc_mul_pkg::*;
#(
    parameter int PW         = 30,
    parameter int DOUT_WIDTH = 30,
    parameter int SHIFT      = 0
) (
    input  logic [PW-1:0]         prod,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam logic [63:0] RND = round_const(SHIFT);

    logic signed [PW:0]       sum;
    logic signed [PW:0]       res;
    logic [PW-DOUT_WIDTH+1:0] hi;

    // One guard bit keeps the rounding add from overflowing.
    assign sum = $signed({prod[PW-1], prod}) + $signed(RND[PW:0]);
    assign res = sum >>> SHIFT;

    // Fits when every bit from the target sign bit up is identical.
    assign hi  = res[PW:DOUT_WIDTH-1];
    assign ovf = !((&hi) || !(|hi));

`ifdef PTCALC_MUL_SAT_EN
    always_comb begin
        dout = res[DOUT_WIDTH-1:0];
        if (ovf) begin
            dout = res[PW] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                           : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
        end
    end
`else
    assign dout = res[DOUT_WIDTH-1:0];
`endif

endmodule

// File: rtl/ptcalc_mul_pipe.sv
// ptcalc_mul_pipe: pipelined signed multiplier, valid/ready, tag sideband.
// In: din0/din1/din_tag/in_valid, out_ready. Out: dout/dout_tag/dout_ovf,
// out_valid, in_ready, ovf_count. Optional macro: PTCALC_MUL_SAT_EN.
module ptcalc_mul_pipe
    import ptcalc_mul_pkg::*;
#(
    parameter int DIN0_WIDTH = 15,
    parameter int DIN1_WIDTH = 15,
    parameter int DOUT_WIDTH = 30,
    parameter int SHIFT      = 0,
    parameter int NUM_STAGE  = 3,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic [TAG_WIDTH-1:0]  din_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic [TAG_WIDTH-1:0]  dout_tag,
    output logic                  dout_ovf,
    output logic [OVF_CNT_W-1:0]  ovf_count
);

    localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);

    generate
        if (!params_ok(DIN0_WIDTH, DIN1_WIDTH, DOUT_WIDTH,
                       SHIFT, NUM_STAGE)) begin : g_bad_params
            $error("ptcalc_mul_pipe: parameter out of range");
        end
    endgenerate

    logic                 adv;
    logic [NUM_STAGE-1:0] vld;
    logic [TAG_WIDTH-1:0] tagq [NUM_STAGE];
    logic [PW-1:0]        a_ext;
    logic [PW-1:0]        b_ext;
    logic [PW-1:0]        prod_c;
    logic [PW-1:0]        rs_in;
    logic [DOUT_WIDTH-1:0] rs_dout;
    logic                 rs_ovf;
    logic [DOUT_WIDTH-1:0] dout_q;
    logic                 ovf_q;
    logic [OVF_CNT_W-1:0] cnt_q;

    // Whole pipe moves together; bubbles are kept, not squeezed out.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign a_ext  = {{(PW-DIN0_WIDTH){din0[DIN0_WIDTH-1]}}, din0};
    assign b_ext  = {{(PW-DIN1_WIDTH){din1[DIN1_WIDTH-1]}}, din1};
    // Low PW bits of a PW x PW product match the signed result.
    assign prod_c = a_ext * b_ext;

    generate
        if (NUM_STAGE == 1) begin : g_comb
            assign rs_in = prod_c;
        end else begin : g_mul
            logic [PW-1:0] pq [NUM_STAGE-1];
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    pq <= '{default: '0};
                end else if (adv) begin
                    pq[0] <= prod_c;
                    for (int i = 1; i < NUM_STAGE - 1; i++) begin
                        pq[i] <= pq[i-1];
                    end
                end
            end
            assign rs_in = pq[NUM_STAGE-2];
        end
    endgenerate

    ptcalc_mul_round_sat #(
        .PW        (PW),
        .DOUT_WIDTH(DOUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_round_sat (
        .prod(rs_in),
        .dout(rs_dout),
        .ovf (rs_ovf)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld    <= '0;
            tagq   <= '{default: '0};
            dout_q <= '0;
            ovf_q  <= 1'b0;
        end else if (adv) begin
            vld[0]  <= in_valid;
            tagq[0] <= din_tag;
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld[i]  <= vld[i-1];
                tagq[i] <= tagq[i-1];
            end
            dout_q <= rs_dout;
            ovf_q  <= rs_ovf;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt_q <= '0;
        end else if (out_valid && out_ready && ovf_q && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_valid = vld[NUM_STAGE-1];
    assign dout_tag  = tagq[NUM_STAGE-1];
    assign dout      = dout_q;
    assign dout_ovf  = ovf_q;
    assign ovf_count = cnt_q;

endmodule

// File: tb/tb_ptcalc_mul_pipe.sv
// tb_ptcalc_mul_pipe: directed table plus stall, saturation, reset runs.
// Three instances share stimulus: defaults, DOUT_WIDTH=16, SHIFT=4/26.
module tb_ptcalc_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [14:0] din0;
    logic [14:0] din1;
    logic [7:0]  din_tag;

    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic [29:0] d0;
    logic [15:0] d1;
    logic [25:0] d2;
    logic [7:0]  t0, t1, t2;
    logic        f0, f1, f2;
    logic [15:0] c0, c1, c2;

    int cmp = 0;
    int errs = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    ptcalc_mul_pipe u0 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ir0),
        .din0(din0), .din1(din1), .din_tag(din_tag),
        .out_valid(ov0), .out_ready(out_ready),
        .dout(d0), .dout_tag(t0), .dout_ovf(f0), .ovf_count(c0)
    );

    ptcalc_mul_pipe #(.DOUT_WIDTH(16)) u1 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ir1),
        .din0(din0), .din1(din1), .din_tag(din_tag),
        .out_valid(ov1), .out_ready(out_ready),
        .dout(d1), .dout_tag(t1), .dout_ovf(f1), .ovf_count(c1)
    );

    ptcalc_mul_pipe #(.DOUT_WIDTH(26), .SHIFT(4)) u2 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ir2),
        .din0(din0), .din1(din1), .din_tag(din_tag),
        .out_valid(ov2), .out_ready(out_ready),
        .dout(d2), .dout_tag(t2), .dout_ovf(f2), .ovf_count(c2)
    );

    typedef struct {
        int         a;
        int         b;
        logic [7:0] tag;
        int         e0;
        int         e1w;
        int         e1s;
        bit         o1;
        int         e2;
    } vec_t;

    vec_t tv [12];

    task automatic chk(input string nm, input longint act, input longint exp);
        cmp++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    function automatic int e1_of(input int k);
`ifdef PTCALC_MUL_SAT_EN
        return tv[k].e1s;
`else
        return tv[k].e1w;
`endif
    endfunction

    task automatic stream(input int first, input int n,
                          input int st0, input int stn);
        int q[$];
        int acc[$];
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int k, ac;
        bit stalled_prev = 0;
        logic [29:0] prev0 = '0;
        while (got < n && cyc < 60) begin
            @(negedge clk);
            in_valid = (sent < n);
            if (sent < n) begin
                din0    = 15'(tv[first+sent].a);
                din1    = 15'(tv[first+sent].b);
                din_tag = tv[first+sent].tag;
            end
            out_ready = !(cyc >= st0 && cyc < st0 + stn);
            #1;
            chk("ovf_count", c1, exp_cnt);
            if (ov0 && !out_ready) chk("in_ready_stall", ir0, 0);
            if (stalled_prev) chk("stall_hold", d0, prev0);
            if (ov0 && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    k  = q.pop_front();
                    ac = acc.pop_front();
                    chk("dout0", $signed(d0), tv[k].e0);
                    chk("tag0", t0, tv[k].tag);
                    chk("ovf0", f0, 0);
                    chk("dout1", $signed(d1), e1_of(k));
                    chk("ovf1", f1, tv[k].o1);
                    chk("tag1", t1, tv[k].tag);
                    chk("dout2", $signed(d2), tv[k].e2);
                    chk("ovf2", f2, 0);
                    if (stn == 0) chk("latency", cyc - ac, 3);
                    if (tv[k].o1 && exp_cnt < 65535) exp_cnt++;
                end
                got++;
            end
            if (in_valid && ir0) begin
                q.push_back(first + sent);
                acc.push_back(cyc);
                sent++;
            end
            stalled_prev = ov0 && !out_ready;
            prev0 = d0;
            cyc++;
        end
        chk("stream_count", got, n);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        tv[0]  = '{-16384, -16384, 8'h5A, 268435456, 0, 32767, 1, 16777216};
        tv[1]  = '{3, 7, 8'h01, 21, 21, 21, 0, 1};
        tv[2]  = '{-3, 7, 8'h02, -21, -21, -21, 0, -1};
        tv[3]  = '{3, -8, 8'h03, -24, -24, -24, 0, -1};
        tv[4]  = '{200, 200, 8'h04, 40000, -25536, 32767, 1, 2500};
        tv[5]  = '{128, 256, 8'h05, 32768, -32768, 32767, 1, 2048};
        tv[6]  = '{-128, 256, 8'h06, -32768, -32768, -32768, 0, -2048};
        tv[7]  = '{8, 1, 8'h07, 8, 8, 8, 0, 1};
        tv[8]  = '{-8, 1, 8'h08, -8, -8, -8, 0, 0};
        tv[9]  = '{16383, -16384, 8'h09, -268419072, 16384, -32768, 1,
                   -16776192};
        tv[10] = '{7, 1, 8'h0A, 7, 7, 7, 0, 0};
        tv[11] = '{-1, -1, 8'h0B, 1, 1, 1, 0, 0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        din0 = '0;
        din1 = '0;
        din_tag = '0;
        #1;
        chk("rst_out_valid", ov0, 0);
        chk("rst_dout", d0, 0);
        chk("rst_tag", t0, 0);
        chk("rst_ovf", f1, 0);
        chk("rst_cnt", c1, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_idle", ir0, 1);

        for (int i = 0; i < 12; i++) stream(i, 1, 0, 0);
        chk("cnt_u0", c0, 0);
        chk("cnt_u2", c2, 0);

        stream(0, 6, 3, 5);

        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        din0 = 15'(200);
        din1 = 15'(200);
        din_tag = 8'hEE;
        repeat (70000) @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("cnt_saturated", c1, 65535);
        @(negedge clk);
        in_valid = 1'b1;
        repeat (8) @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("cnt_holds", c1, 65535);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            din0 = 15'(tv[4+i].a);
            din1 = 15'(tv[4+i].b);
            din_tag = tv[4+i].tag;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("inflight_valid", ov0, 1);
        chk("inflight_ovf", f1, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", ov0, 0);
        chk("mid_rst_dout", d1, 0);
        chk("mid_rst_tag", t0, 0);
        chk("mid_rst_ovf", f1, 0);
        chk("mid_rst_cnt", c1, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        begin
            int seen = 0;
            repeat (8) begin
                @(negedge clk);
                #1;
                if (ov0 || ov1 || ov2) seen++;
            end
            chk("no_out_after_rst", seen, 0);
        end
        stream(4, 1, 0, 0);
        @(negedge clk);
        #1;
        chk("cnt_after_rst", c1, exp_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
